// File: rtl/fetch_sequencer.sv
// fetch_sequencer: instruction fetch FSM (IDLE -> FETCH -> LOAD -> EXEC).
//   FETCH raises memRead at memAddr=pc until memReady, LOAD pulses notLoadIR
//   low for one cycle and bumps pc, EXEC holds irValid until execDone (with an
//   optional jump via jumpE/jumpAddr).
// Optional feature: define FETCH_TIMEOUT_EN to add a fetch wait watchdog that
//   sets the sticky fault flag and parks the FSM in HALT (left only by reset).
//   Without the macro, fault is tied to 0 and HALT is unreachable.
// Ports:
//   clock, reset           - rising-edge clock, async active-high reset
//   start                  - run enable (sampled at IDLE and at end of EXEC)
//   memReady               - memory data valid (only looked at in FETCH)
//   execDone, jumpE        - execute complete / take jumpAddr (only in EXEC)
//   jumpAddr[15:0]         - branch target
//   memAddr[15:0], memRead - fetch address (= pc) and read request
//   notLoadIR              - active-low IR load strobe
//   irValid                - IR holds an instruction being executed
//   pc[15:0]               - program counter
//   fault                  - sticky fetch timeout flag
module fetch_sequencer #(
  parameter logic [15:0] RESET_PC       = 16'h0000,
  parameter int          TIMEOUT_CYCLES = 15
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic        memReady,
  input  logic        execDone,
  input  logic        jumpE,
  input  logic [15:0] jumpAddr,
  output logic [15:0] memAddr,
  output logic        memRead,
  output logic        notLoadIR,
  output logic        irValid,
  output logic [15:0] pc,
  output logic        fault
);

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] FETCH = 3'd1;
  localparam logic [2:0] LOAD  = 3'd2;
  localparam logic [2:0] EXEC  = 3'd3;
  localparam logic [2:0] HALT  = 3'd4;

  logic [2:0] state, state_nxt;
  logic       tmo_hit;

`ifdef FETCH_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] tmo_cnt;

  // Fires on the last of TIMEOUT_CYCLES consecutive not-ready FETCH cycles.
  assign tmo_hit = (state == FETCH) && !memReady &&
                   (tmo_cnt == CW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      tmo_cnt <= '0;
      fault   <= 1'b0;
    end else begin
      if (state != FETCH)
        tmo_cnt <= '0;               // so every FETCH entry starts from zero
      else if (!memReady && !tmo_hit)
        tmo_cnt <= tmo_cnt + 1'b1;
      if (tmo_hit)
        fault <= 1'b1;
    end
  end
`else
  assign tmo_hit = 1'b0;
  assign fault   = 1'b0;
`endif

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (start) state_nxt = FETCH;
      FETCH: begin
        if (memReady)     state_nxt = LOAD;
        else if (tmo_hit) state_nxt = HALT;
      end
      LOAD:  state_nxt = EXEC;
      // start is only re-examined here, so dropping it mid-instruction
      // lets the instruction finish before returning to IDLE.
      EXEC:  if (execDone) state_nxt = start ? FETCH : IDLE;
      HALT:  state_nxt = HALT;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      pc    <= RESET_PC;
    end else begin
      state <= state_nxt;
      if (state == LOAD)
        pc <= pc + 16'd1;            // wraps modulo 2^16
      else if (state == EXEC && execDone && jumpE)
        pc <= jumpAddr;
    end
  end

  // Moore outputs decoded from the registered state, so an async reset
  // releases the strobes immediately.
  assign memAddr   = pc;
  assign memRead   = (state == FETCH) || (state == LOAD);
  assign notLoadIR = (state != LOAD);
  assign irValid   = (state == EXEC);

endmodule

// File: tb/tb_fetch_sequencer.sv
module tb_fetch_sequencer;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0, memReady = 1'b0, execDone = 1'b0, jumpE = 1'b0;
  logic [15:0] jumpAddr = 16'h0000;
  logic [15:0] memAddr, pc;
  logic        memRead, notLoadIR, irValid, fault;

  int n_vec = 0;
  int n_bad = 0;

  fetch_sequencer #(.RESET_PC(16'h0000), .TIMEOUT_CYCLES(15)) dut (
    .clock(clock), .reset(reset), .start(start), .memReady(memReady),
    .execDone(execDone), .jumpE(jumpE), .jumpAddr(jumpAddr),
    .memAddr(memAddr), .memRead(memRead), .notLoadIR(notLoadIR),
    .irValid(irValid), .pc(pc), .fault(fault)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic        s, mr, ed, je;
    logic [15:0] ja;
    logic [15:0] pc;
    logic        rd, nld, irv;
  } vec_t;

  typedef struct {
    int          idx;
    logic [15:0] pc;
    logic        rd, nld, irv;
  } exp_t;

  vec_t vecs[17];
  exp_t sb[$];

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic cyc(input logic s, input logic mr, input logic ed,
                     input logic je, input logic [15:0] ja);
    @(negedge clock);
    start = s; memReady = mr; execDone = ed; jumpE = je; jumpAddr = ja;
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset = 1'b1;
    start = 1'b0; memReady = 1'b0; execDone = 1'b0; jumpE = 1'b0; jumpAddr = '0;
    #2 reset = 1'b0;
  endtask

  function automatic vec_t mk(input logic s, input logic mr, input logic ed,
                              input logic je, input logic [15:0] ja,
                              input logic [15:0] p, input logic rd,
                              input logic nld, input logic irv);
    vec_t v;
    v.s = s; v.mr = mr; v.ed = ed; v.je = je; v.ja = ja;
    v.pc = p; v.rd = rd; v.nld = nld; v.irv = irv;
    return v;
  endfunction

  initial begin
    // Each row: inputs for one clock edge, expected outputs just after it.
    //           s  mr ed je  ja        pc       rd nld irv
    vecs[0]  = mk(1, 1, 0, 0, 16'h0000, 16'h0000, 1, 1, 0); // IDLE->FETCH
    vecs[1]  = mk(1, 1, 0, 0, 16'h0000, 16'h0000, 1, 0, 0); // LOAD
    vecs[2]  = mk(1, 1, 0, 0, 16'h0000, 16'h0001, 0, 1, 1); // EXEC, pc bumped
    vecs[3]  = mk(1, 1, 1, 0, 16'h0000, 16'h0001, 1, 1, 0); // FETCH @1
    vecs[4]  = mk(1, 1, 1, 0, 16'h0000, 16'h0001, 1, 0, 0); // execDone ignored
    vecs[5]  = mk(1, 1, 0, 0, 16'h0000, 16'h0002, 0, 1, 1); // EXEC
    vecs[6]  = mk(1, 1, 1, 0, 16'h0000, 16'h0002, 1, 1, 0); // FETCH @2
    vecs[7]  = mk(1, 0, 0, 0, 16'h0000, 16'h0002, 1, 1, 0); // wait for memReady
    vecs[8]  = mk(1, 1, 0, 0, 16'h0000, 16'h0002, 1, 0, 0); // LOAD
    vecs[9]  = mk(1, 0, 0, 0, 16'h0000, 16'h0003, 0, 1, 1); // EXEC
    vecs[10] = mk(1, 0, 1, 1, 16'h1234, 16'h1234, 1, 1, 0); // jump taken
    vecs[11] = mk(1, 0, 0, 1, 16'h5555, 16'h1234, 1, 1, 0); // jumpE ignored
    vecs[12] = mk(0, 1, 0, 0, 16'h0000, 16'h1234, 1, 0, 0); // start drop: no abort
    vecs[13] = mk(0, 1, 0, 0, 16'h0000, 16'h1235, 0, 1, 1); // EXEC
    vecs[14] = mk(0, 0, 0, 0, 16'h0000, 16'h1235, 0, 1, 1); // hold in EXEC
    vecs[15] = mk(0, 0, 1, 0, 16'h0000, 16'h1235, 0, 0 | 1, 0); // -> IDLE
    vecs[16] = mk(0, 1, 0, 0, 16'h0000, 16'h1235, 0, 1, 0); // stays IDLE

    // Reset state, checked while reset is held.
    #3;
    chk("rst_pc", pc, 16'h0000);
    chk("rst_memRead", {15'd0, memRead}, 16'd0);
    chk("rst_notLoadIR", {15'd0, notLoadIR}, 16'd1);
    chk("rst_irValid", {15'd0, irValid}, 16'd0);
    chk("rst_fault", {15'd0, fault}, 16'd0);
    do_reset();

    for (int i = 0; i < 17; i++) begin
      exp_t e;
      @(negedge clock);
      start = vecs[i].s; memReady = vecs[i].mr; execDone = vecs[i].ed;
      jumpE = vecs[i].je; jumpAddr = vecs[i].ja;
      e.idx = i; e.pc = vecs[i].pc; e.rd = vecs[i].rd;
      e.nld = vecs[i].nld; e.irv = vecs[i].irv;
      sb.push_back(e);
      @(posedge clock);
      #1;
      e = sb.pop_front();
      chk($sformatf("v%0d_pc", e.idx), pc, e.pc);
      chk($sformatf("v%0d_memAddr", e.idx), memAddr, e.pc);
      chk($sformatf("v%0d_memRead", e.idx), {15'd0, memRead}, {15'd0, e.rd});
      chk($sformatf("v%0d_notLoadIR", e.idx), {15'd0, notLoadIR}, {15'd0, e.nld});
      chk($sformatf("v%0d_irValid", e.idx), {15'd0, irValid}, {15'd0, e.irv});
    end

    // memReady delayed 5 cycles: 6 FETCH cycles, then one LOAD, pc bumps after.
    begin
      int n_rd = 0;
      do_reset();
      cyc(1, 0, 0, 0, 16'h0);
      for (int k = 0; k < 6; k++) begin
        if (memRead && notLoadIR) n_rd++;
        cyc(1, (k == 5), 0, 0, 16'h0);
      end
      chk("dly_fetch_cycles", 16'(n_rd), 16'd6);
      chk("dly_load_strobe", {15'd0, notLoadIR}, 16'd0);
      chk("dly_pc_in_load", pc, 16'h0000);
      cyc(1, 0, 0, 0, 16'h0);
      chk("dly_pc_after_load", pc, 16'h0001);
      chk("dly_load_once", {15'd0, notLoadIR}, 16'd1);
    end

    // pc wrap at 16'hFFFF.
    cyc(1, 0, 1, 1, 16'hFFFF);
    chk("wrap_memAddr", memAddr, 16'hFFFF);
    cyc(1, 1, 0, 0, 16'h0);
    cyc(1, 0, 0, 0, 16'h0);
    chk("wrap_pc", pc, 16'h0000);
    chk("wrap_irValid", {15'd0, irValid}, 16'd1);

    // Async reset mid-LOAD at pc=7.
    cyc(1, 0, 1, 1, 16'h0007);
    cyc(1, 1, 0, 0, 16'h0);
    chk("mid_load_pc", pc, 16'h0007);
    chk("mid_load_strobe", {15'd0, notLoadIR}, 16'd0);
    #2 reset = 1'b1;
    #1;
    chk("async_rst_notLoadIR", {15'd0, notLoadIR}, 16'd1);
    chk("async_rst_pc", pc, 16'h0000);
    chk("async_rst_memRead", {15'd0, memRead}, 16'd0);
    reset = 1'b0;
    cyc(0, 1, 0, 0, 16'h0);
    chk("post_rst_idle", {15'd0, memRead}, 16'd0);

    // Reset wins over execDone+jumpE at the same edge.
    cyc(1, 1, 0, 0, 16'h0);
    cyc(1, 1, 0, 0, 16'h0);
    cyc(1, 0, 0, 0, 16'h0);
    chk("prio_in_exec", {15'd0, irValid}, 16'd1);
    @(negedge clock);
    execDone = 1'b1; jumpE = 1'b1; jumpAddr = 16'hABCD; reset = 1'b1;
    @(posedge clock);
    #1;
    chk("prio_pc", pc, 16'h0000);
    chk("prio_irValid", {15'd0, irValid}, 16'd0);
    chk("prio_memRead", {15'd0, memRead}, 16'd0);
    reset = 1'b0;

    // Fetch timeout behaviour.
    do_reset();
    cyc(1, 0, 0, 0, 16'h0);
    for (int k = 0; k < 14; k++) cyc(1, 0, 0, 0, 16'h0);
    chk("tmo_before_fault", {15'd0, fault}, 16'd0);
    chk("tmo_before_memRead", {15'd0, memRead}, 16'd1);
    cyc(1, 0, 0, 0, 16'h0);
`ifdef FETCH_TIMEOUT_EN
    chk("tmo_fault", {15'd0, fault}, 16'd1);
    chk("tmo_memRead", {15'd0, memRead}, 16'd0);
    for (int k = 0; k < 4; k++) cyc(1, 1, 1, 0, 16'h0);
    chk("halt_stays", {14'd0, memRead, irValid}, 16'd0);
    chk("halt_fault_sticky", {15'd0, fault}, 16'd1);
    do_reset();
    #1;
    chk("halt_reset_fault", {15'd0, fault}, 16'd0);
`else
    chk("notmo_fault", {15'd0, fault}, 16'd0);
    chk("notmo_memRead", {15'd0, memRead}, 16'd1);
    for (int k = 0; k < 10; k++) cyc(1, 0, 0, 0, 16'h0);
    chk("notmo_still_fetch", {15'd0, memRead}, 16'd1);
    cyc(1, 1, 0, 0, 16'h0);
    chk("notmo_load", {15'd0, notLoadIR}, 16'd0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/fetch_sequencer.md
FETCH_SEQUENCER -- requirements
Module: fetch_sequencer

Interface
REQ-001 SHALL have parameter RESET_PC, default 16'h0000: PC value loaded on reset.
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 15: fetch wait limit, used only with FETCH_TIMEOUT_EN.
REQ-003 SHALL have port clock  in  1: sole clock, rising edge.
REQ-004 SHALL have port reset  in  1: asynchronous, active-high reset.
REQ-005 SHALL have port start  in  1: run enable; fetching proceeds while high.
REQ-006 SHALL have port memReady  in  1: memory has driven the instruction word onto data_bus.
REQ-007 SHALL have port execDone  in  1: execute unit finished the current instruction.
REQ-008 SHALL have port jumpE  in  1: qualifies execDone; PC takes jumpAddr.
REQ-009 SHALL have port jumpAddr  in  16: branch target.
REQ-010 SHALL have port memAddr  out  16: fetch address, equal to pc.
REQ-011 SHALL have port memRead  out  1: active-high memory read request.
REQ-012 SHALL have port notLoadIR  out  1: active-low load strobe to the instruction register.
REQ-013 SHALL have port irValid  out  1: IR holds an instruction awaiting execution.
REQ-014 SHALL have port pc  out  16: program counter.
REQ-015 SHALL have port fault  out  1: fetch timeout flag, sticky.

Function
REQ-016 SHALL implement the FSM states IDLE, FETCH, LOAD, EXEC and HALT, all registered and changing only on the rising clock edge.
REQ-017 IDLE SHALL drive all outputs inactive and SHALL move to FETCH on the first edge with start=1.
REQ-018 FETCH SHALL drive memRead=1 and memAddr=pc, and SHALL hold until memReady=1 is sampled, then move to LOAD.
REQ-019 LOAD SHALL drive notLoadIR=0 for exactly one cycle, keep memRead=1 so data_bus remains valid, set pc<=pc+1 at its closing edge, then move to EXEC.
REQ-020 PC increment SHALL be modulo 2^16, so 16'hFFFF+1 gives 16'h0000 with no flag.
REQ-021 EXEC SHALL drive irValid=1 with memRead=0 and notLoadIR=1, and SHALL hold until execDone=1.
REQ-022 On execDone=1 in EXEC, the FSM SHALL go to FETCH if start=1, else to IDLE.
REQ-023 If jumpE=1 at that same edge, pc SHALL take jumpAddr; otherwise pc SHALL be unchanged.
REQ-024 start deasserted during FETCH, LOAD or EXEC SHALL NOT abort; the current instruction SHALL complete and the FSM SHALL then enter IDLE.
REQ-025 memReady outside FETCH, and execDone/jumpE outside EXEC, SHALL be ignored.
REQ-026 Minimum fetch-to-irValid latency SHALL be 2 cycles: FETCH with memReady=1, then LOAD.

Reset
REQ-027 reset=1 SHALL, asynchronously and from any state, force state=IDLE, pc=RESET_PC, memRead=0, notLoadIR=1, irValid=0 and fault=0.
REQ-028 reset SHALL take priority over every simultaneous input, including execDone with jumpE.
REQ-029 Reset during LOAD SHALL return notLoadIR high immediately and SHALL leave pc unincremented.

Configuration
REQ-030 Macro FETCH_TIMEOUT_EN defined: a counter SHALL count consecutive FETCH cycles with memReady=0.
REQ-031 With the macro, reaching TIMEOUT_CYCLES SHALL set fault=1, drop memRead and enter HALT.
REQ-032 HALT SHALL be left only by reset.
REQ-033 With the macro, the counter SHALL clear on FETCH entry.
REQ-034 Macro FETCH_TIMEOUT_EN undefined: FETCH SHALL wait indefinitely, HALT SHALL be unreachable, and fault SHALL be constant 0 (port retained).

Verification
REQ-035 Reset, start=1, memReady=1 held, execDone pulsed in every EXEC -> memAddr sequence 0,1,2; exactly one notLoadIR low cycle per instruction.
REQ-036 memReady delayed 5 cycles -> memRead high for 6 cycles, then one LOAD cycle; pc 0->1 only after LOAD.
REQ-037 execDone=1 with jumpE=1, jumpAddr=16'h1234 -> next memAddr=16'h1234; pc=16'hFFFF then LOAD -> pc=16'h0000.
REQ-038 start dropped during FETCH -> instruction completes through EXEC, then IDLE with memRead=0.
REQ-039 reset asserted mid-LOAD at pc=16'h0007 -> notLoadIR=1 and pc=RESET_PC without waiting for a clock edge.
REQ-040 FETCH_TIMEOUT_EN defined, memReady=0 held -> fault=1 after 15 FETCH cycles, memRead=0, state stays HALT until reset.
